// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD bus controller: turns command/data requests from the
// core LCD register into timed RS/DATA/EN transactions, with an optional power-up init.
module lcd_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 4,
  parameter int T_PW    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 80000,
  parameter bit INIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lcd_reg,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        overrun
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_SETUP), max_of(T_PW, T_HOLD)),
                                max_of(T_EXEC, T_CLR));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {PWR_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             go_q, req, done, is_clr;
  logic             pending, pend_rs;
  logic [7:0]       pend_data;
  logic             in_init;
  logic [1:0]       init_idx, init_sel;
  logic             load_new, load_pend, load_init;
  logic             capture, drop;
  logic             unused_bits;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  assign unused_bits = ^{lcd_reg[30:11], lcd_reg[8]};

  assign req     = lcd_reg[10] & ~go_q;
  assign is_clr  = ~lcd_rs & ((lcd_data == 8'h01) | (lcd_data == 8'h02));
  assign done    = (cnt == cnt_last);
  assign busy    = (state != IDLE) | pending;
  assign lcd_rw  = 1'b0;

  // A request goes straight to the bus only from IDLE with nothing queued.
  assign capture = req & ~pending & ~(state == IDLE);
  assign drop    = req & pending;

  always_comb begin
    cnt_last = '0;
    case (state)
      PWR_WAIT: cnt_last = CNT_W'(T_PWRUP - 1);
      SETUP:    cnt_last = CNT_W'(T_SETUP - 1);
      PULSE:    cnt_last = CNT_W'(T_PW - 1);
      HOLD:     cnt_last = CNT_W'(T_HOLD - 1);
      EXEC:     cnt_last = is_clr ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
      default:  cnt_last = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load_new  = 1'b0;
    load_pend = 1'b0;
    load_init = 1'b0;
    init_sel  = (state == PWR_WAIT) ? 2'd0 : init_idx + 2'd1;
    case (state)
      PWR_WAIT: if (done) begin
        state_nxt = INIT_EN ? SETUP : IDLE;
        load_init = INIT_EN;
      end
      IDLE: begin
        if (pending) begin
          load_pend = 1'b1;
          state_nxt = SETUP;
        end else if (req) begin
          load_new  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: if (done) state_nxt = PULSE;
      PULSE: if (done) state_nxt = HOLD;
      HOLD:  if (done) state_nxt = EXEC;
      EXEC: if (done) begin
        // Init bytes own the bus until the last one; queued requests wait for IDLE.
        if (in_init) begin
          if (init_idx == 2'd3) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SETUP;
            load_init = 1'b1;
          end
        end else if (pending) begin
          load_pend = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PWR_WAIT;
      cnt      <= '0;
      go_q     <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      in_init  <= 1'b0;
      init_idx <= 2'd0;
      lcd_on   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + 1'b1;
      go_q   <= lcd_reg[10];
      lcd_on <= lcd_reg[31];
      lcd_en <= (state_nxt == PULSE);
      if (load_pend)
        pending <= 1'b0;
      if (capture)
        pending <= 1'b1;
      if (drop)
        overrun <= 1'b1;
      if (load_init) begin
        in_init  <= 1'b1;
        init_idx <= init_sel;
      end else if ((state == EXEC) && done && in_init) begin
        in_init <= 1'b0;
      end
    end
  end

  // RS/DATA only move on SETUP entry, so they are frozen through PULSE and HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      pend_rs   <= 1'b0;
      pend_data <= 8'h00;
    end else begin
      if (capture) begin
        pend_rs   <= lcd_reg[9];
        pend_data <= lcd_reg[7:0];
      end
      if (load_new) begin
        lcd_rs   <= lcd_reg[9];
        lcd_data <= lcd_reg[7:0];
      end else if (load_pend) begin
        lcd_rs   <= pend_rs;
        lcd_data <= pend_data;
      end else if (load_init) begin
        lcd_rs   <= 1'b0;
        lcd_data <= init_byte(init_sel);
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: two instances (with and without init) share one stimulus stream;
// a timing-level reference model predicts every bus transaction, busy and overrun.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_PW    = 3;
  localparam int T_HOLD  = 1;
  localparam int T_EXEC  = 10;
  localparam int T_CLR   = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lcd_reg = 32'h0;
  logic        on_o   [2];
  logic        en_o   [2];
  logic        rs_o   [2];
  logic        rw_o   [2];
  logic [7:0]  data_o [2];
  logic        busy_o [2];
  logic        ovr_o  [2];

  int compared = 0;
  int mismatched = 0;
  int nrise [2];

  initial forever #5 clk = ~clk;

  lcd_ctrl #(.T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_PW(T_PW), .T_HOLD(T_HOLD),
             .T_EXEC(T_EXEC), .T_CLR(T_CLR), .INIT_EN(1'b1)) dut_init (
    .clk(clk), .rst(rst_n), .lcd_reg(lcd_reg), .lcd_on(on_o[0]), .lcd_en(en_o[0]),
    .lcd_rs(rs_o[0]), .lcd_rw(rw_o[0]), .lcd_data(data_o[0]), .busy(busy_o[0]),
    .overrun(ovr_o[0]));

  lcd_ctrl #(.T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_PW(T_PW), .T_HOLD(T_HOLD),
             .T_EXEC(T_EXEC), .T_CLR(T_CLR), .INIT_EN(1'b0)) dut_noinit (
    .clk(clk), .rst(rst_n), .lcd_reg(lcd_reg), .lcd_on(on_o[1]), .lcd_en(en_o[1]),
    .lcd_rs(rs_o[1]), .lcd_rw(rw_o[1]), .lcd_data(data_o[1]), .busy(busy_o[1]),
    .overrun(ovr_o[1]));

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Cycles a transaction keeps the controller busy, from SETUP entry to IDLE.
  function automatic int dur(input int rs, input int d);
    return T_SETUP + T_PW + T_HOLD + (((rs == 0) && (d == 1 || d == 2)) ? T_CLR : T_EXEC);
  endfunction

  function automatic int init_val(input int k);
    case (k)
      0:       return 'h38;
      1:       return 'h0C;
      2:       return 'h01;
      default: return 'h06;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : chk_g
    localparam bit INIT = (g == 0);
    // Expected transactions: RS, DATA and the cycle index at which EN should rise.
    int q_rs[$];
    int q_d[$];
    int q_t[$];
    int ec, busy_until, pend_until, s;
    bit last_direct, ovr, on_exp, go_prev, req;
    bit en_prev;
    int width, hold_left, cur_rs, cur_d, e;

    // Reference model: advances once per clock edge; edge index ec counts from reset release.
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ec = 0; ovr = 0; on_exp = 0; go_prev = 0; last_direct = 0; pend_until = -1;
        q_rs.delete(); q_d.delete(); q_t.delete();
        busy_until = T_PWRUP;
        if (INIT) begin
          for (int k = 0; k < 4; k++) begin
            q_rs.push_back(0);
            q_d.push_back(init_val(k));
            q_t.push_back(busy_until + T_SETUP);
            busy_until += dur(0, init_val(k));
          end
        end
      end else begin
        on_exp  = lcd_reg[31];
        req     = lcd_reg[10] && !go_prev;
        go_prev = lcd_reg[10];
        if (req) begin
          if (ec <= pend_until) begin
            ovr = 1;
          end else begin
            if (ec >= busy_until)
              s = ec + 1;
            else begin
              // Queued: chained straight after EXEC only when captured before its last cycle.
              s = (last_direct && (ec + 1 < busy_until)) ? busy_until : busy_until + 1;
              pend_until = s - 1;
            end
            q_rs.push_back(int'(lcd_reg[9]));
            q_d.push_back(int'(lcd_reg[7:0]));
            q_t.push_back(s + T_SETUP);
            busy_until = s + dur(int'(lcd_reg[9]), int'(lcd_reg[7:0]));
            last_direct = 1;
          end
        end
        ec++;
      end
    end

    // Monitor: samples outputs mid-cycle and pops the expected queue on each EN rise.
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_prev = 0; width = 0; hold_left = 0;
      end else begin
        e = ec;
        chk($sformatf("u%0d lcd_rw", g), int'(rw_o[g]), 0);
        chk($sformatf("u%0d lcd_on", g), int'(on_o[g]), int'(on_exp));
        chk($sformatf("u%0d busy cyc%0d", g, e), int'(busy_o[g]), int'(e < busy_until));
        chk($sformatf("u%0d overrun cyc%0d", g, e), int'(ovr_o[g]), int'(ovr));
        if (en_o[g] && !en_prev) begin
          nrise[g]++;
          if (q_t.size() == 0) begin
            chk($sformatf("u%0d unexpected EN rise cyc%0d", g, e), 1, 0);
          end else begin
            chk($sformatf("u%0d EN rise cycle", g), e, q_t.pop_front());
            chk($sformatf("u%0d lcd_rs", g), int'(rs_o[g]), q_rs.pop_front());
            chk($sformatf("u%0d lcd_data", g), int'(data_o[g]), q_d.pop_front());
          end
          cur_rs = int'(rs_o[g]);
          cur_d  = int'(data_o[g]);
          width  = 1;
        end else if (en_o[g]) begin
          width++;
          chk($sformatf("u%0d rs stable in pulse", g), int'(rs_o[g]), cur_rs);
          chk($sformatf("u%0d data stable in pulse", g), int'(data_o[g]), cur_d);
        end else if (en_prev) begin
          chk($sformatf("u%0d EN width", g), width, T_PW);
          hold_left = T_HOLD;
        end
        if (!en_o[g] && hold_left > 0) begin
          chk($sformatf("u%0d rs stable in hold", g), int'(rs_o[g]), cur_rs);
          chk($sformatf("u%0d data stable in hold", g), int'(data_o[g]), cur_d);
          hold_left--;
        end
        en_prev = en_o[g];
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy_o[0] || busy_o[1]) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle within cycle budget", int'(!(busy_o[0] || busy_o[1])), 1);
  endtask

  task automatic send(input logic [31:0] v);
    @(negedge clk);
    lcd_reg = v | 32'h0000_0400;
    @(negedge clk);
    lcd_reg = v & ~32'h0000_0400;
  endtask

  task automatic random_traffic(input int ncyc);
    logic [31:0] nv;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      nv = $urandom;
      nv[10] = ($urandom_range(5) == 0) ? ~lcd_reg[10] : lcd_reg[10];
      nv[31] = ($urandom_range(15) == 0) ? ~lcd_reg[31] : lcd_reg[31];
      if ($urandom_range(3) == 0)
        nv[7:0] = 8'($urandom_range(1, 2));
      lcd_reg = nv;
    end
    @(negedge clk);
    lcd_reg[10] = 1'b0;
  endtask

  initial begin
    int r0, r1, n;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset lcd_en", k), int'(en_o[k]), 0);
      chk($sformatf("u%0d reset lcd_rs", k), int'(rs_o[k]), 0);
      chk($sformatf("u%0d reset lcd_data", k), int'(data_o[k]), 0);
      chk($sformatf("u%0d reset lcd_on", k), int'(on_o[k]), 0);
      chk($sformatf("u%0d reset busy", k), int'(busy_o[k]), 1);
      chk($sformatf("u%0d reset overrun", k), int'(ovr_o[k]), 0);
    end
    #1 rst_n = 1'b1;
    wait_idle(300);
    chk("init EN pulse count", nrise[0], 4);
    chk("no-init EN pulse count", nrise[1], 0);

    send(32'h8000_0241);
    wait_idle(100);
    send(32'h8000_0001);
    wait_idle(100);

    send(32'h8000_0030);
    repeat (5) @(negedge clk);
    send(32'h8000_0031);
    repeat (2) @(negedge clk);
    send(32'h8000_0032);
    wait_idle(200);
    chk("u0 overrun after double queue", int'(ovr_o[0]), 1);
    chk("u1 overrun after double queue", int'(ovr_o[1]), 1);

    r0 = nrise[0];
    r1 = nrise[1];
    @(negedge clk);
    lcd_reg = 32'h8000_0455;
    repeat (100) @(negedge clk);
    lcd_reg = 32'h8000_0055;
    wait_idle(100);
    chk("u0 pulses for held GO", nrise[0] - r0, 1);
    chk("u1 pulses for held GO", nrise[1] - r1, 1);

    random_traffic(900);
    wait_idle(2000);

    send(32'h8000_0233);
    n = 0;
    while (!en_o[0] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("EN seen before mid-pulse reset", int'(en_o[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("u0 lcd_en dropped by async reset", int'(en_o[0]), 0);
    chk("u1 lcd_en dropped by async reset", int'(en_o[1]), 0);
    chk("u0 overrun cleared by reset", int'(ovr_o[0]), 0);
    chk("u0 busy during reset", int'(busy_o[0]), 1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    random_traffic(300);
    wait_idle(2000);
    repeat (3) @(negedge clk);
    chk("u0 expected transactions left", chk_g[0].q_t.size(), 0);
    chk("u1 expected transactions left", chk_g[1].q_t.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
